conv_win_ctrl: RTL and testbench

CONV_WIN_CTRL -- requirements
Module: conv_win_ctrl

---
 rtl/conv_win_ctrl_if.sv | 33 +++
 rtl/conv_win_ctrl.sv | 134 +++++++++++++
 tb/tb_conv_win_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_win_ctrl_if.sv
// Handshake and window-status bundle between the pixel stream, the SIPO
// line buffer and the downstream window consumer.
interface conv_win_ctrl_if #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Handshake: a pixel moves when in_valid && in_ready in the same cycle;
  // in_valid must not depend on in_ready, in_ready may depend on out_ready.
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          shift_en;
  logic          sipo_clr;
  logic          win_valid;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          busy;
  logic          done;

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, shift_en, sipo_clr, win_valid, win_col, win_row, busy, done
  );

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, shift_en, sipo_clr, win_valid, win_col, win_row, busy, done
  );
endinterface

// File: rtl/conv_win_ctrl.sv
// Sequences an N-deep pixel SIPO across an IMG_W x IMG_H frame and flags
// each cycle in which the SIPO holds a complete N-pixel window.
module conv_win_ctrl #(
  parameter int N     = 3,
  parameter int PB    = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic            clk,
  input  logic            rst,
  conv_win_ctrl_if.slave  bus,
  output logic [2:0]      dbg_state_o
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // An illegal parameter set leaves the controller parked in IDLE.
  localparam bit CFG_OK = (N >= 2) && (PB >= 1) && (IMG_W >= N) && (IMG_H >= 1);

  localparam logic [CW-1:0] COL_PRE_RUN = CW'(N - 2);
  localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_RUN     = 3'd2,
    S_ROW_END = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          first_q, first_d;
  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic          in_ready;
  logic          xfer;

  // The first FILL cycle is spent clearing the SIPO, so no pixel is taken then.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_FILL:  in_ready = !first_q;
      S_RUN:   in_ready = bus.out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign xfer = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    first_d     = 1'b0;
    win_valid_d = 1'b0;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && CFG_OK) begin
          col_d   = '0;
          row_d   = '0;
          first_d = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (xfer) begin
          col_d = col_q + 1'b1;
          if (col_q == COL_PRE_RUN) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          win_valid_d = 1'b1;
          win_col_d   = col_q;
          win_row_d   = row_q;
          // col stays at the last column until ROW_END clears it.
          if (col_q == COL_LAST) begin
            state_d = (row_q == ROW_LAST) ? S_DONE : S_ROW_END;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_ROW_END: begin
        row_d   = row_q + 1'b1;
        col_d   = '0;
        first_d = 1'b1;
        state_d = S_FILL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      first_q     <= 1'b0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      first_q     <= first_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.shift_en  = xfer;
  assign bus.sipo_clr  = (state_q == S_FILL) && first_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_col   = win_col_q;
  assign bus.win_row   = win_row_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_conv_win_ctrl.sv
// Scoreboarded bench for conv_win_ctrl: an 8x2 frame with N=3 under several
// stimulus patterns, plus a minimal 3x1 instance.
module tb_conv_win_ctrl;
  localparam int N     = 3;
  localparam int PB    = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 2;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int WINS  = (IMG_W - N + 1) * IMG_H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_win_ctrl_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();
  conv_win_ctrl_if #(.IMG_W(3), .IMG_H(1)) bus_s ();
  logic [2:0] dbg_state;
  logic [2:0] dbg_state_s;

  conv_win_ctrl #(.N(N), .PB(PB), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  conv_win_ctrl #(.N(3), .PB(PB), .IMG_W(3), .IMG_H(1)) u_dut_s (
    .clk(clk), .rst(rst), .bus(bus_s), .dbg_state_o(dbg_state_s)
  );

  // ---------------- scoreboard ----------------
  logic [CW+RW-1:0] exp_q[$];
  logic [CW+RW-1:0] exp_e;
  int total = 0;
  int bad   = 0;
  int cyc = 0, last_xfer_cyc = 0;
  int frame_xfer = 0, win_cnt = 0, clr_cnt = 0, done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < IMG_H; r++)
      for (int c = N - 1; c < IMG_W; c++)
        exp_q.push_back({RW'(r), CW'(c)});
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("shift_en", bus.shift_en, bus.in_valid && bus.in_ready);
      if (!bus.busy) frame_xfer = 0;
      if (bus.sipo_clr) begin
        clr_cnt++;
        check("clr_ready", bus.in_ready, 0);
      end
      if (bus.shift_en) begin
        frame_xfer++;
        last_xfer_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        check("done_xfers", frame_xfer, IMG_W * IMG_H);
        check("done_lag", cyc - last_xfer_cyc, 1);
      end
      if (bus.win_valid) begin
        win_cnt++;
        check("win_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check("win_pos", {bus.win_row, bus.win_col}, exp_e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_sipo_clr"}, bus.sipo_clr, 0);
    check({tag, "_win_valid"}, bus.win_valid, 0);
    check({tag, "_win_col"}, bus.win_col, 0);
    check({tag, "_win_row"}, bus.win_row, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // mode 0: in_valid always 1; 1: toggling; 2: random.
  task automatic run_frame(input int mode, input int stall_win, input bit hold_start);
    int base_win, base_clr, base_done, stall_left, k;
    bit seen_done, stalled;
    base_win = win_cnt; base_clr = clr_cnt; base_done = done_cnt;
    stall_left = 0; stalled = 0; seen_done = 0;
    push_frame();
    bus.start = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 1'b0;
    for (int c = 0; c < 3000 && !seen_done; c++) begin
      case (mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = c[0];
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      if (!stalled && stall_win >= 0 && (win_cnt - base_win) == stall_win && dbg_state == 3'd2) begin
        stalled = 1; stall_left = 5;
      end
      bus.out_ready = (stall_left == 0);
      @(negedge clk);
      if (stall_left > 0) begin
        k = 5 - stall_left;
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_shift_en", bus.shift_en, 0);
        if (k > 0) check("stall_win_valid", bus.win_valid, 0);
        stall_left--;
      end
      @(posedge clk); #1;
      seen_done = bus.done;
    end
    check("frame_done_seen", seen_done, 1);
    if (stall_win >= 0) check("stall_happened", stalled, 1);
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_done_busy", bus.busy, 0);
    check("frame_wins", win_cnt - base_win, WINS);
    check("frame_clrs", clr_cnt - base_clr, IMG_H);
    check("frame_dones", done_cnt - base_done, 1);
    check("exp_q_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_abort();
    int base_done;
    base_done = done_cnt;
    push_frame();
    bus.start = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1;
    for (int c = 0; c < 200 && frame_xfer < IMG_W + 4; c++) begin
      @(posedge clk); #1;
    end
    check("abort_pos", frame_xfer, IMG_W + 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    check_idle("abort");
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - base_done, 0);
  endtask

  task automatic run_small();
    int wins;
    bit seen_done;
    wins = 0; seen_done = 0;
    bus_s.start = 1'b1; bus_s.in_valid = 1'b1; bus_s.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_s.start = 1'b0;
    for (int c = 0; c < 50 && !seen_done; c++) begin
      @(negedge clk);
      if (bus_s.win_valid) begin
        wins++;
        check("small_col", bus_s.win_col, 2);
        check("small_row", bus_s.win_row, 0);
      end
      seen_done = bus_s.done;
    end
    check("small_done", seen_done, 1);
    check("small_wins", wins, 1);
    @(posedge clk); #1;
    check("small_busy", bus_s.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1;
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus_s.start = 1'b0; bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", bus.busy, 0);

    run_frame(0, -1, 1'b0);
    run_frame(1, -1, 1'b0);
    run_frame(0, 3, 1'b0);
    run_frame(0, -1, 1'b1);
    run_frame(0, -1, 1'b0);
    run_abort();
    run_frame(0, -1, 1'b0);
    run_frame(2, -1, 1'b0);
    run_small();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
